// File: rtl/uart_fizzbuzz_core.sv
`default_nettype none
// uart_fizzbuzz_core: byte-stream FizzBuzz term generator driven by UART commands 'r', 'n', 'c'.
// Define FB_WORDS_EN to emit Fizz/Buzz/FizzBuzz words; otherwise every term is the plain number.
module uart_fizzbuzz_core #(
  parameter int NUM_DIGITS = 3,
  parameter int CNT_MAX    = 100,
  parameter int FIZZ_DIV   = 3,
  parameter int BUZZ_DIV   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_busy
);
  localparam int CW = 4 * NUM_DIGITS;

  function automatic logic [CW-1:0] bcd_of(input int v);
    int t;
    t = v;
    bcd_of = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      bcd_of[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  localparam logic [CW-1:0] MAX_BCD = bcd_of(CNT_MAX);

  if (FIZZ_DIV < 2 || BUZZ_DIV < 2 || CNT_MAX >= 10 ** NUM_DIGITS) begin : g_param_check
    $error("uart_fizzbuzz_core: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, SEL, SEND, GUARD, NEXT, ADV} state_t;
  typedef enum logic [1:0] {K_NUM, K_FIZZ, K_BUZZ, K_FB} kind_t;

  state_t        state;
  kind_t         kind;
  kind_t         kind_sel;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic          inc_carry;
  logic [7:0]    len;
  logic [7:0]    idx;
  logic [7:0]    msd_len;
  logic [7:0]    dsel;
  logic [3:0]    digit;
  logic [7:0]    char_out;
  logic          buzz_half;
  logic          run;
  logic          stop;

`ifdef FB_WORDS_EN
  localparam int FW = $clog2(FIZZ_DIV);
  localparam int BW = $clog2(BUZZ_DIV);
  logic [FW-1:0] fmod;
  logic [BW-1:0] bmod;

  always_comb begin
    kind_sel = K_NUM;
    if (fmod == '0 && bmod == '0) kind_sel = K_FB;
    else if (fmod == '0)          kind_sel = K_FIZZ;
    else if (bmod == '0)          kind_sel = K_BUZZ;
  end
`else
  always_comb kind_sel = K_NUM;
`endif

  // BCD ripple increment; CNT_MAX folds back to zero.
  always_comb begin
    count_inc = count;
    inc_carry = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (inc_carry) begin
        if (count[4*k +: 4] == 4'd9) begin
          count_inc[4*k +: 4] = 4'd0;
        end else begin
          count_inc[4*k +: 4] = count[4*k +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
    if (count == MAX_BCD) count_inc = '0;
  end

  // Number of digits from the most-significant nonzero one; zero still shows one digit.
  always_comb begin
    msd_len = 8'd1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (count[4*k +: 4] != 4'd0) msd_len = 8'(k + 1);
    end
  end

  always_comb begin
    dsel  = len - idx - 8'd1;
    digit = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (8'(k) == dsel) digit = count[4*k +: 4];
    end
    buzz_half = (kind == K_BUZZ) || (kind == K_FB && idx[2]);
    if (idx == len)          char_out = 8'h0D;
    else if (idx > len)      char_out = 8'h0A;
    else if (kind == K_NUM)  char_out = {4'h3, digit};
    else begin
      case (idx[1:0])
        2'd0:    char_out = buzz_half ? "B" : "F";
        2'd1:    char_out = buzz_half ? "u" : "i";
        default: char_out = "z";
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kind       <= K_NUM;
      count      <= '0;
      len        <= 8'd1;
      idx        <= 8'd0;
      run        <= 1'b0;
      stop       <= 1'b0;
      o_tx_data  <= 8'd0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
`ifdef FB_WORDS_EN
      fmod       <= '0;
      bmod       <= '0;
`endif
    end else begin
      o_tx_valid <= 1'b0;
      // Any byte arriving during a continuous run ends it after the current term.
      if (run && state != IDLE && i_rx_valid) stop <= 1'b1;
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              "r": begin
                count  <= '0;
`ifdef FB_WORDS_EN
                fmod   <= '0;
                bmod   <= '0;
`endif
                o_busy <= 1'b1;
                state  <= SEL;
              end
              "n": begin
                o_busy <= 1'b1;
                state  <= SEL;
              end
              "c": begin
                run    <= 1'b1;
                o_busy <= 1'b1;
                state  <= SEL;
              end
              default: ;
            endcase
          end
        end
        SEL: begin
          kind  <= kind_sel;
          len   <= (kind_sel == K_NUM) ? msd_len : (kind_sel == K_FB) ? 8'd8 : 8'd4;
          idx   <= 8'd0;
          state <= SEND;
        end
        SEND: begin
          if (!i_tx_busy) begin
            o_tx_data  <= char_out;
            o_tx_valid <= 1'b1;
            state      <= GUARD;
          end
        end
        GUARD: state <= NEXT;
        NEXT: begin
          if (idx > len) begin
            state <= ADV;
          end else begin
            idx   <= idx + 8'd1;
            state <= SEND;
          end
        end
        ADV: begin
          count <= count_inc;
`ifdef FB_WORDS_EN
          if (count == MAX_BCD) begin
            fmod <= '0;
            bmod <= '0;
          end else begin
            fmod <= (fmod == FW'(FIZZ_DIV - 1)) ? '0 : fmod + 1'b1;
            bmod <= (bmod == BW'(BUZZ_DIV - 1)) ? '0 : bmod + 1'b1;
          end
`endif
          if (run && !stop && !i_rx_valid && count != MAX_BCD) begin
            state <= SEL;
          end else begin
            run    <= 1'b0;
            stop   <= 1'b0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/uart_fizzbuzz_core.md
Name: uart_fizzbuzz_core

Overview:
- Byte-stream FizzBuzz engine. Sits between the uart_rx byte output and the uart_tx byte input.
- Host commands advance a decimal counter. For each step the block emits one full term as ASCII: "Fizz", "Buzz", "FizzBuzz" or the multi-digit number, always followed by CR LF.
- Generalises the single-digit responder with these parameters: digit count, divisors, wrap point, and a continuous-run mode.

Parameters:
- NUM_DIGITS, 3, number of BCD digits in the counter. Must satisfy CNT_MAX < 10**NUM_DIGITS.
- CNT_MAX, 100, last counter value. The counter wraps from CNT_MAX to 0.
- FIZZ_DIV, 3, divisor for "Fizz". Must be ≥ 2.
- BUZZ_DIV, 5, divisor for "Buzz". Must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data
- i_tx_busy  in  1  transmitter busy
- o_tx_data  out  8  byte to transmit
- o_tx_valid  out  1  one-cycle transmit strobe
- o_busy  out  1  term emission in progress

Behaviour:
- Reset and clock:
  - Reset is rst, synchronous, active-high; clock is clk.
  - Reset values: o_tx_data=0, o_tx_valid=0, o_busy=0, count=0, both mod counters=0, run flag=0, FSM=IDLE.
  - rst mid-emission aborts immediately. No further bytes are sent.
- Counter representation:
  - NUM_DIGITS BCD digits, plus mod counters fmod (0..FIZZ_DIV-1) and bmod (0..BUZZ_DIV-1) that track count.
  - Increment: BCD ripple carry; each mod counter wraps to 0 at its divisor-1.
  - At CNT_MAX the increment sets count, fmod and bmod all to 0.
- Commands (accepted only in IDLE, on i_rx_valid):
  - 'r': clear count/fmod/bmod to 0, then emit term for 0, then increment.
  - 'n': emit term for current count, then increment.
  - 'c': set run flag; emit terms repeatedly. Stops after the term for CNT_MAX, or after the current term completes if any i_rx_valid arrives during the run. That stop byte is consumed and not decoded.
  - Any other byte in IDLE: ignored.
  - Bytes received while o_busy=1 outside 'c' mode: dropped.
- Term selection:
  - fmod==0 and bmod==0 -> "FizzBuzz"
  - fmod==0 only -> "Fizz"
  - bmod==0 only -> "Buzz"
  - otherwise the decimal value with leading zeros suppressed. At least one digit is always sent.
  - Value 0 therefore emits "FizzBuzz".
  - Every term ends with 0x0D 0x0A.
- FSM states:
  - IDLE -> SEL on a valid command.
  - SEL: latch term kind and first character index (most-significant nonzero digit for numbers). Go to SEND.
  - SEND: wait until i_tx_busy==0, then drive o_tx_valid=1 with o_tx_data for exactly 1 cycle. Go to GUARD.
  - GUARD: 1 cycle during which i_tx_busy is ignored, covering the transmitter's busy-rise latency. Go to NEXT.
  - NEXT: advance the character pointer. Go to SEND if characters remain, else ADV.
  - ADV: increment the counter. Go to SEL if run flag set and not stopped and the term just sent was not for CNT_MAX; otherwise clear run flag and go to IDLE.
- Timing:
  - o_tx_valid is low in every state except the SEND accept cycle. o_tx_data holds its last value otherwise.
  - o_busy is high from the cycle after command acceptance until the cycle ADV goes to IDLE.
  - Latency: command at cycle N with tx idle gives o_tx_valid at N+2.
  - Adjacent bytes are separated by at least 3 cycles plus transmitter busy time.
- Wrap: 'n' issued at count=CNT_MAX emits that term, and the next 'n' emits the term for 0 ("FizzBuzz").

Optional Feature:
- Macro: FB_WORDS_EN.
- Defined: term selection as above.
- Undefined: fmod/bmod logic is not built and every term is the plain decimal number plus CR LF. Value 0 emits "0\r\n".

Test Plan:
- rst, then 'r' -> bytes "FizzBuzz",0x0D,0x0A; o_busy then falls. Then 'n','n','n' -> "1\r\n", "2\r\n", "Fizz\r\n".
- 'r', then 'n' ×14 (count reaches 14), then 'n' -> last term "FizzBuzz\r\n"; the following 'n' -> "16\r\n".
- CNT_MAX=12, NUM_DIGITS=2: 'r' then 'n'×12, then 'n' -> terms end "11\r\n", "Fizz\r\n" (12), then "FizzBuzz\r\n" (wrap to 0).
- 'c' with CNT_MAX=5 -> exactly 6 terms: FizzBuzz,1,2,Fizz,4,Buzz; o_busy low afterwards. Repeat 'c' with a stop byte injected during term 2 -> emission ends after "2\r\n".
- Hold i_tx_busy=1 for 50 cycles during a term -> o_tx_valid stays low, no byte lost, order preserved. Send 'n' while o_busy=1 -> ignored.
- rst asserted mid "FizzBuzz" -> no o_tx_valid after reset. Next 'n' -> "FizzBuzz\r\n" (count restarted at 0).
